// File: rtl/gates_sweep_ctrl_pkg.sv
// Shared definitions for the gate-function sweep sequencer: state encoding,
// default expected truth table and settle-time bounds.
package gates_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int         SETTLE_MIN       = 1;
  localparam int         SETTLE_MAX       = 15;
  localparam int         SETTLE_DEFAULT   = 2;
  localparam logic [7:0] EXPECTED_DEFAULT = 8'h7B;

  // Timer reload value; an out-of-range SETTLE is clamped into 1..15.
  function automatic logic [3:0] settle_load(input int settle);
    int s;
    s = (settle < SETTLE_MIN) ? SETTLE_MIN : ((settle > SETTLE_MAX) ? SETTLE_MAX : settle);
    return 4'(s - 1);
  endfunction

endpackage

// File: rtl/gates_sweep_ctrl_if.sv
// Board-control handshake plus the A/B/C/F pins of the function under test.
interface gates_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       f;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [7:0] table_out;

  modport slave (
    input  start, abort, f,
    output a, b, c, busy, done, pass, err_cnt, table_out
  );

  modport master (
    output start, abort, f,
    input  a, b, c, busy, done, pass, err_cnt, table_out
  );
endinterface

// File: rtl/gates_sweep_ctrl_timer.sv
// 4-bit loadable down-counter; holds at zero and flags it.
module gates_sweep_ctrl_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_val,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_cnt <= 4'd0;
    else if (i_load)         r_cnt <= i_val;
    else if (r_cnt != 4'd0)  r_cnt <= r_cnt - 4'd1;
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/gates_sweep_ctrl.sv
// Self-test sequencer: walks {a,b,c} through 000..111, samples f after a
// settle time and scores the observed truth table against EXPECTED.
module gates_sweep_ctrl
  import gates_sweep_ctrl_pkg::*;
#(
  parameter int         SETTLE   = SETTLE_DEFAULT,
  parameter logic [7:0] EXPECTED = EXPECTED_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  gates_sweep_ctrl_if.slave  bus
);

  localparam logic [3:0] LP_LOAD = settle_load(SETTLE);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_vec;
  logic [7:0] r_table;
  logic [3:0] r_err;
  logic       r_pass;
  logic       r_busy;
  logic       r_done;

  logic       w_accept;
  logic       w_last;
  logic       w_mis;
  logic [3:0] w_err_nxt;
  logic       w_tmr_load;
  logic [3:0] w_tmr_val;
  logic       w_tmr_zero;
  logic       w_busy_nxt;
  logic       w_done_nxt;

  assign w_accept  = (r_state == ST_IDLE) && bus.start && !bus.abort;
  assign w_last    = (r_vec == 3'd7);
  assign w_mis     = bus.f ^ EXPECTED[r_vec];
  assign w_err_nxt = r_err + {3'b000, w_mis};

  // Abort parks the timer at zero; otherwise reload for each new vector.
  assign w_tmr_load = bus.abort || w_accept || ((r_state == ST_SAMPLE) && !w_last);
  assign w_tmr_val  = bus.abort ? 4'd0 : LP_LOAD;

  gates_sweep_ctrl_timer u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_zero (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.start) w_state_nxt = ST_WAIT;
      ST_WAIT:   if (w_tmr_zero) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = w_last ? ST_DONE : ST_WAIT;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (bus.abort) w_state_nxt = ST_IDLE;
  end

  // Outputs are decoded from the next state so the registered flags line up with the state.
  always_comb begin
    w_busy_nxt = (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_SAMPLE);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec   <= 3'd0;
      r_table <= 8'd0;
      r_err   <= 4'd0;
      r_pass  <= 1'b0;
    end else if (bus.abort) begin
      r_vec  <= 3'd0;
      r_pass <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_vec   <= 3'd0;
            r_table <= 8'd0;
            r_err   <= 4'd0;
            r_pass  <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          r_table[r_vec] <= bus.f;
          r_err          <= w_err_nxt;
          // pass is set on entry to DONE so it is valid alongside the done pulse.
          if (w_last) r_pass <= (w_err_nxt == 4'd0);
          else        r_vec  <= r_vec + 3'd1;
        end
        ST_DONE: r_vec <= 3'd0;
        default: ;
      endcase
    end
  end

  // The vector register is the pin drive: 111 through DONE, 000 in IDLE.
  assign bus.a         = r_vec[2];
  assign bus.b         = r_vec[1];
  assign bus.c         = r_vec[0];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_cnt   = r_err;
  assign bus.table_out = r_table;

endmodule

// File: tb/tb_gates_sweep_ctrl.sv
// Scoreboard bench for gates_sweep_ctrl: two instances (SETTLE=2 and SETTLE=1),
// each driving a table-defined gate function, checked against a truth-table model.
module tb_gates_sweep_ctrl;
  import gates_sweep_ctrl_pkg::*;

  localparam int         S0  = 2;
  localparam int         S1  = 1;
  localparam logic [7:0] EXP = 8'h7B;

  logic   clk = 1'b0;
  logic   rst0_n;
  logic   rst1_n;
  longint cyc = 0;
  logic [7:0] tt0;
  logic [7:0] tt1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gates_sweep_ctrl_if if0 ();
  gates_sweep_ctrl_if if1 ();

  // The function under test is simply a lookup table indexed by {a,b,c}.
  assign if0.f = tt0[{if0.a, if0.b, if0.c}];
  assign if1.f = tt1[{if1.a, if1.b, if1.c}];

  gates_sweep_ctrl #(.SETTLE(S0), .EXPECTED(EXP)) u0 (.clk(clk), .rst_n(rst0_n), .bus(if0));
  gates_sweep_ctrl #(.SETTLE(S1), .EXPECTED(EXP)) u1 (.clk(clk), .rst_n(rst1_n), .bus(if1));

  typedef struct {
    logic [7:0] tbl;
    int         err;
    bit         pass;
    longint     s;
    int         settle;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   nvec = 0;
  int   nmis = 0;

  task automatic check(input string nm, input longint act, input longint req);
    nvec++;
    if (act != req) begin
      nmis++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] tt, input int settle, input longint s);
    exp_t       e;
    logic [7:0] ex;
    ex       = EXP;
    e.tbl    = tt;
    e.err    = 0;
    for (int i = 0; i < 8; i++) if (tt[i] != ex[i]) e.err++;
    e.pass   = (e.err == 0);
    e.s      = s;
    e.settle = settle;
    return e;
  endfunction

  // done is seen on the falling edge inside its cycle; the edge that ends it completes the count.
  task automatic mon_one(input int inst);
    exp_t       e;
    logic [7:0] tbl;
    logic [3:0] err;
    logic       ps;
    int         qs;
    if (inst == 0) begin tbl = if0.table_out; err = if0.err_cnt; ps = if0.pass; qs = q0.size(); end
    else           begin tbl = if1.table_out; err = if1.err_cnt; ps = if1.pass; qs = q1.size(); end
    if (qs == 0) begin
      nvec++;
      nmis++;
      $display("FAIL unexpected_done inst%0d: got a done pulse, required none", inst);
      return;
    end
    if (inst == 0) e = q0.pop_front();
    else           e = q1.pop_front();
    check($sformatf("table_out inst%0d", inst), tbl, e.tbl);
    check($sformatf("err_cnt inst%0d", inst), err, e.err);
    check($sformatf("pass inst%0d", inst), ps, e.pass);
    check($sformatf("done_latency inst%0d", inst), cyc - e.s + 1, 8 * (e.settle + 1) + 1);
  endtask

  function automatic logic [17:0] outs(input int inst);
    if (inst == 0) return {if0.a, if0.b, if0.c, if0.busy, if0.done, if0.pass, if0.err_cnt, if0.table_out};
    return {if1.a, if1.b, if1.c, if1.busy, if1.done, if1.pass, if1.err_cnt, if1.table_out};
  endfunction

  // Pulse start for one cycle from IDLE; optionally queue the expected result.
  task automatic kick(input int inst, input logic [7:0] tt, input bit track);
    longint s;
    @(negedge clk);
    if (inst == 0) begin tt0 = tt; if0.start = 1'b1; end
    else           begin tt1 = tt; if1.start = 1'b1; end
    @(posedge clk);
    #1;
    s = cyc;
    if (inst == 0) begin
      if0.start = 1'b0;
      check("busy_after_start inst0", if0.busy, 1);
      check("pass_cleared inst0", if0.pass, 0);
      if (track) q0.push_back(model(tt, S0, s));
    end else begin
      if1.start = 1'b0;
      check("busy_after_start inst1", if1.busy, 1);
      check("pass_cleared inst1", if1.pass, 0);
      if (track) q1.push_back(model(tt, S1, s));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending_results", q0.size() + q1.size(), 0);
  endtask

  task automatic wait_abc0(input logic [2:0] v);
    int n = 0;
    while ({if0.a, if0.b, if0.c} != v && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_vector_reached", {if0.a, if0.b, if0.c}, v);
  endtask

  task automatic stimulus();
    logic [7:0] ta;
    logic [7:0] tb;
    logic [7:0] ex;
    longint     s;
    int         perr;
    int         n;
    ex = EXP;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs inst0", outs(0), 0);
    check("reset_outputs inst1", outs(1), 0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs inst0", outs(0), 0);

    // Correct function: vectors walk 000..111, each held SETTLE+1 cycles
    kick(0, EXP, 1);
    for (int k = 0; k < 8 * (S0 + 1); k++) begin
      @(negedge clk);
      check($sformatf("abc_walk k%0d", k), {if0.a, if0.b, if0.c}, k / (S0 + 1));
    end
    drain();
    repeat (3) @(negedge clk);
    check("pass_held", if0.pass, 1);
    check("abc_idle", {if0.a, if0.b, if0.c}, 0);

    // f stuck at 0 (SETTLE=2) and stuck at 1 (SETTLE=1)
    kick(0, 8'h00, 1);
    drain();
    kick(1, 8'hFF, 1);
    drain();

    // Random functions on both instances with overlapping sweeps
    for (int it = 0; it < 8; it++) begin
      ta = 8'($urandom);
      tb = 8'($urandom);
      if (it % 3 == 0) ta = EXP;
      if (it % 4 == 1) tb = EXP;
      kick(0, ta, 1);
      repeat ($urandom_range(0, 10)) @(negedge clk);
      kick(1, tb, 1);
      drain();
    end

    // Abort during vector 3 WAIT: partial results kept, no done, pass cleared
    ta = 8'($urandom);
    kick(0, ta, 0);
    wait_abc0(3'd3);
    if0.abort = 1'b1;
    @(posedge clk);
    #1;
    if0.abort = 1'b0;
    perr = 0;
    for (int i = 0; i < 3; i++) if (ta[i] != ex[i]) perr++;
    check("abort_busy", if0.busy, 0);
    check("abort_abc", {if0.a, if0.b, if0.c}, 0);
    check("abort_pass", if0.pass, 0);
    check("abort_table_partial", if0.table_out, {5'b00000, ta[2:0]});
    check("abort_err_partial", if0.err_cnt, perr);
    repeat (4) @(negedge clk);
    check("abort_stays_idle", if0.busy, 0);

    // abort and start together in IDLE: sweep must not start
    if0.start = 1'b1;
    if0.abort = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    if0.abort = 1'b0;
    check("abort_beats_start_busy", if0.busy, 0);
    check("abort_beats_start_table", if0.table_out, {5'b00000, ta[2:0]});
    kick(0, EXP, 1);
    drain();

    // start held high: one sweep, then a second beginning the cycle after DONE
    @(negedge clk);
    tt0 = EXP;
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    s = cyc;
    q0.push_back(model(EXP, S0, s));
    q0.push_back(model(EXP, S0, s + 8 * (S0 + 1) + 2));
    n = 0;
    while (!if0.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("held_start_done_seen", if0.done, 1);
    @(posedge clk);
    #1;
    check("held_start_idle_busy", if0.busy, 0);
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    check("held_start_second_busy", if0.busy, 1);
    check("held_start_second_abc", {if0.a, if0.b, if0.c}, 0);
    drain();

    // Reset asserted during vector 5 SAMPLE
    kick(0, EXP, 0);
    wait_abc0(3'd5);
    repeat (S0) @(negedge clk);
    #2;
    rst0_n = 1'b0;
    #1;
    check("midsweep_reset_outputs", outs(0), 0);
    repeat (2) @(negedge clk);
    rst0_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_idle", outs(0), 0);
    kick(0, EXP, 1);
    drain();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst0_n    = 1'b0;
    rst1_n    = 1'b0;
    if0.start = 1'b0;
    if0.abort = 1'b0;
    if1.start = 1'b0;
    if1.abort = 1'b0;
    tt0       = EXP;
    tt1       = EXP;
    fork
      begin
        forever begin
          @(negedge clk);
          if (if0.done) mon_one(0);
          if (if1.done) mon_one(1);
        end
      end
      begin
        stimulus();
      end
      begin
        repeat (20000) @(posedge clk);
        nvec++;
        nmis++;
        $display("FAIL watchdog: got no completion within 20000 cycles, required completion");
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
